// File: rtl/alu_pkg.sv
// Shared codes, error encodings and FSM state type for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] DTYPE_U = 4'h1;
  localparam logic [3:0] DTYPE_S = 4'h2;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_MUL = 5'h04;
  localparam logic [4:0] OP_DIV = 5'h08;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_OVF     = 2'b11;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StArith,
    StIter,
    StFix
  } alu_state_e;

  function automatic logic code_valid(input logic [3:0] dtype, input logic [4:0] op);
    return ((dtype == DTYPE_U) || (dtype == DTYPE_S)) &&
           ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV));
  endfunction

endpackage

// File: rtl/alu_iter_engine.sv
// Shared shift datapath: shift-add multiply or restoring divide on W-bit magnitudes.
module alu_iter_engine
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           load,
  input  logic           mode,
  input  logic [W-1:0]   a_mag,
  input  logic [W-1:0]   b_mag,
  input  logic           step,
  output logic [2*W-1:0] out
);

  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic [W-1:0] m_q;
  logic         mode_q;

  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] trial;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[W-1]};
    trial   = shifted[W-1:0] - m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (load) begin
      hi_d = '0;
      lo_d = a_mag;
    end else if (step) begin
      if (mode_q == MODE_DIV) begin
        // Partial remainder lives in hi, quotient bits shift into lo.
        if (shifted >= {1'b0, m_q}) begin
          hi_d = trial;
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = shifted[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = sum[W:1];
        lo_d = {sum[0], lo_q[W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      mode_q <= MODE_MUL;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (load) begin
        m_q    <= b_mag;
        mode_q <= mode;
      end
    end
  end

  // Divide presents {quotient, remainder}; multiply presents the full product.
  assign out = (mode_q == MODE_DIV) ? {lo_q, hi_q} : {hi_q, lo_q};

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle integer ALU: add/sub in one cycle, mul/div via a shared W-step engine.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic [3:0]     dtype,
  input  logic [4:0]     op,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [1:0]     err
);

  localparam int unsigned CntW = $clog2(W) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);
  localparam logic [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

  alu_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, b_q;
  logic [3:0]      dtype_q;
  logic [4:0]      op_q;
  logic [2*W-1:0]  result_q, result_d;
  logic [1:0]      err_q, err_d;
  logic            done_q, done_d;

  logic            accept, step;
  logic            in_sgn;
  logic [W-1:0]    mag1, mag2;
  logic [2*W-1:0]  eng_out;

  logic            sgn, neg_ab, neg_a;
  logic [2*W-1:0]  ext_a, ext_b;
  logic [W-1:0]    quo, rem;

  // Magnitudes are formed from the raw inputs so the engine loads on the accept edge.
  always_comb begin
    in_sgn = (dtype == DTYPE_S);
    mag1   = (in_sgn && src1[W-1]) ? -src1 : src1;
    mag2   = (in_sgn && src2[W-1]) ? -src2 : src2;
  end

  alu_iter_engine #(
    .W (W)
  ) u_engine (
    .clk   (clk),
    .n_rst (n_rst),
    .load  (accept),
    .mode  (op == OP_DIV ? MODE_DIV : MODE_MUL),
    .a_mag (mag1),
    .b_mag (mag2),
    .step  (step),
    .out   (eng_out)
  );

  always_comb begin
    sgn    = (dtype_q == DTYPE_S);
    neg_a  = sgn && a_q[W-1];
    neg_ab = sgn && (a_q[W-1] ^ b_q[W-1]);
    ext_a  = sgn ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
    ext_b  = sgn ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
    quo    = neg_ab ? -eng_out[2*W-1:W] : eng_out[2*W-1:W];
    rem    = neg_a ? -eng_out[W-1:0] : eng_out[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (!code_valid(dtype, op) || (op == OP_ADD) || (op == OP_SUB) ||
              ((op == OP_DIV) && (src2 == '0))) begin
            state_d = StArith;
          end else begin
            state_d = StIter;
          end
        end
      end
      StArith: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (!code_valid(dtype_q, op_q)) begin
          err_d    = ERR_INVALID;
          result_d = '0;
        end else if (op_q == OP_DIV) begin
          err_d    = ERR_DIV0;
          result_d = {{W{1'b1}}, a_q};
        end else if (op_q == OP_SUB) begin
          err_d    = ERR_OK;
          result_d = ext_a - ext_b;
        end else begin
          err_d    = ERR_OK;
          result_d = ext_a + ext_b;
        end
      end
      StIter: begin
        step = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        err_d   = ERR_OK;
        if (op_q == OP_MUL) begin
          result_d = neg_ab ? -eng_out : eng_out;
        end else if (sgn && (a_q == MinVal) && (b_q == '1)) begin
          err_d    = ERR_OVF;
          result_d = {MinVal, {W{1'b0}}};
        end else begin
          result_d = {quo, rem};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dtype_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
      if (accept) begin
        a_q     <= src1;
        b_q     <= src2;
        dtype_q <= dtype;
        op_q    <= op;
      end
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at W=16 with hand-computed expectations.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     dtype = '0;
  logic [4:0]     op = '0;
  logic [W-1:0]   src1 = '0;
  logic [W-1:0]   src2 = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic [1:0]     err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_iter #(
    .W (W)
  ) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .dtype  (dtype),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Starts one operation, scrambles inputs after acceptance, and measures latency.
  // poke > 0 raises an extra start at that cycle, which must be ignored while busy.
  task automatic run_op(input string tag, input logic [3:0] dt, input logic [4:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                        input logic [2*W-1:0] exp_res, input logic [1:0] exp_err,
                        input int poke);
    int k;
    k = 0;
    @(negedge clk);
    dtype = dt; op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; src1 = ~a; src2 = ~b; op = OP_SUB; dtype = DTYPE_S;
    check_eq({tag, "/busy"}, 64'(busy), 64'd1);
    while (!done && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (poke > 0 && k == poke && !done) begin
        start = 1'b1; op = OP_ADD; dtype = DTYPE_U;
        check_eq({tag, "/busy_at_poke"}, 64'(busy), 64'd1);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "/latency"}, 64'(k), 64'(lat));
    check_eq({tag, "/result"}, 64'(result), 64'(exp_res));
    check_eq({tag, "/err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    logic seen_done;

    repeat (2) @(negedge clk);
    check_eq("reset/busy", 64'(busy), 64'd0);
    check_eq("reset/done", 64'(done), 64'd0);
    check_eq("reset/result", 64'(result), 64'd0);
    check_eq("reset/err", 64'(err), 64'd0);
    n_rst = 1'b1;

    run_op("uadd", DTYPE_U, OP_ADD, 16'hFFFF, 16'h0001, 1, 32'h0001_0000, 2'b00, 0);
    run_op("usub", DTYPE_U, OP_SUB, 16'h0003, 16'h0005, 1, 32'hFFFF_FFFE, 2'b00, 0);
    run_op("sadd", DTYPE_S, OP_ADD, 16'h8000, 16'hFFFF, 1, 32'hFFFF_7FFF, 2'b00, 0);
    run_op("smul", DTYPE_S, OP_MUL, 16'hFFFD, 16'h0007, 17, 32'hFFFF_FFEB, 2'b00, 5);
    run_op("umul", DTYPE_U, OP_MUL, 16'hFFFF, 16'hFFFF, 17, 32'hFFFE_0001, 2'b00, 0);
    run_op("sdiv", DTYPE_S, OP_DIV, 16'hFFF9, 16'h0002, 17, 32'hFFFD_FFFF, 2'b00, 0);
    run_op("sdiv_negb", DTYPE_S, OP_DIV, 16'h0007, 16'hFFFE, 17, 32'hFFFD_0001, 2'b00, 0);
    run_op("udiv", DTYPE_U, OP_DIV, 16'hFFFF, 16'h0007, 17, 32'h2492_0001, 2'b00, 0);
    run_op("sdiv_ovf", DTYPE_S, OP_DIV, 16'h8000, 16'hFFFF, 17, 32'h8000_0000, 2'b11, 0);
    run_op("bad_op", DTYPE_U, 5'h03, 16'h1111, 16'h2222, 1, 32'h0000_0000, 2'b01, 0);
    run_op("bad_dtype", 4'h3, OP_ADD, 16'h1111, 16'h2222, 1, 32'h0000_0000, 2'b01, 0);
    run_op("udiv0", DTYPE_U, OP_DIV, 16'h1234, 16'h0000, 1, 32'hFFFF_1234, 2'b10, 0);

    // Reset in the middle of a multiply: no done, all outputs cleared.
    @(negedge clk);
    dtype = DTYPE_U; op = OP_MUL; src1 = 16'h1234; src2 = 16'h0100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_eq("midrst/busy", 64'(busy), 64'd0);
    check_eq("midrst/done", 64'(done), 64'd0);
    check_eq("midrst/result", 64'(result), 64'd0);
    check_eq("midrst/err", 64'(err), 64'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen_done = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      seen_done |= done;
    end
    check_eq("midrst/no_done", 64'(seen_done), 64'd0);

    // Back-to-back: add requested in the multiply's done cycle.
    run_op("b2b_mul", DTYPE_U, OP_MUL, 16'h1234, 16'h0100, 17, 32'h0012_3400, 2'b00, 0);
    dtype = DTYPE_U; op = OP_ADD; src1 = 16'h00FF; src2 = 16'h0101; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b/busy", 64'(busy), 64'd1);
    check_eq("b2b/done_drop", 64'(done), 64'd0);
    @(negedge clk);
    check_eq("b2b/done", 64'(done), 64'd1);
    check_eq("b2b/result", 64'(result), 64'h0000_0200);
    check_eq("b2b/err", 64'(err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parameterised, multi-cycle integer ALU. It performs add, sub, mul and div on W-bit operands and returns a 2W-bit result. It is the next-generation ALU behind the UART calculator command decoder and replaces the fixed 16-bit datapath. A single FSM owns a start/busy/done handshake, one shared iterative mul/div engine and explicit error reporting. The block never quietly holds a stale result.

## Interface
Parameters:
- W, 16: operand width, ≥4. Result width is 2W.

Ports:
- clk, in, 1: clock, rising edge.
- n_rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: request. Sampled only while busy=0.
- dtype, in, 4: 4'h1 unsigned, 4'h2 signed. Any other value is invalid.
- op, in, 5: 5'h01 add, 5'h02 sub, 5'h04 mul, 5'h08 div. Any other value is invalid.
- src1, in, W: first operand (dividend for div).
- src2, in, W: second operand (divisor for div).
- busy, out, 1: operation in flight.
- done, out, 1: one-cycle pulse; result and err are valid from this cycle.
- result, out, 2W: registered. Holds its value until the next done.
- err, out, 2: 2'b00 ok, 2'b01 invalid op/dtype, 2'b10 divide by zero, 2'b11 signed div overflow.

## Operation
- Reset values: state IDLE, busy=0, done=0, err=2'b00, result=0. Reset asserted mid-operation aborts the operation with no done pulse.
- FSM states: IDLE, ARITH, ITER, FIX.
  - IDLE to ARITH: start with add/sub, or any invalid code, or div with src2=0.
  - IDLE to ITER: start with mul/div.
  - ITER to FIX: after exactly W iterations.
  - ARITH and FIX: go to IDLE and pulse done.
- Operands, dtype and op are latched when start is accepted. Input changes afterwards have no effect.
- Unsigned add: result = {(W-1)'b0, carry, sum}.
- Unsigned sub: zero-extend both operands to 2W, then subtract. A negative difference sign-fills the upper bits.
- Signed add/sub: sign-extend both operands to 2W, then add/subtract in 2W bits. No overflow is possible.
- Mul: shift-add over the operand magnitudes for W cycles, producing a 2W-bit product. In signed mode, FIX negates the product when the operand signs differ.
- Div: restoring division on magnitudes for W cycles. result = {quotient[W-1:0], remainder[W-1:0]}.
  - Signed mode truncates toward zero. The quotient is negated when the signs differ. The remainder takes the sign of the dividend.
- Divide by zero: err=2'b10, result = {all-ones, src1}. Takes the ARITH path, so latency is 1.
- Signed MIN / -1: err=2'b11, result = {MIN, 0}. This is detected in FIX.
- Invalid op or dtype: err=2'b01, result=0, latency 1.
- start while busy=1: ignored. There is no queue and no error.

## Timing
- Define edge N as the clock edge where start=1 and busy=0.
- busy goes high after edge N.
- add/sub/error cases: done and result are valid after edge N+1, so latency is 1 cycle.
- mul/div: iterations occur on edges N+1 through N+W; FIX and done occur after edge N+W+1. Latency is W+1 cycles (17 for W=16).
- busy falls on the same edge that done rises. A start held high during the done cycle is accepted, giving back-to-back throughput with no idle cycle.
- The iteration counter is $clog2(W)+1 bits wide, loads 0 at edge N and ends at W-1.

## Structure
- Package alu_pkg holds:
  - the DTYPE_U and DTYPE_S constants;
  - the OP_ADD, OP_SUB, OP_MUL and OP_DIV codes;
  - the ERR_* codes;
  - the FSM state encoding.
- Sub-module alu_iter_engine is the shared mul/div shift datapath. Its interface is load, mode, W-bit magnitude inputs, a step enable and a 2W-bit output.
- The top level contains the FSM, sign handling, the add/sub adders, error detection and the output registers.

## Test plan
All scenarios use W=16.
- Unsigned add 0xFFFF + 0x0001 → result 0x0001_0000, err 00, done 1 cycle after the start edge.
- Unsigned sub 0x0003 − 0x0005 → result 0xFFFF_FFFE. Signed add 0x8000 + 0xFFFF → result 0xFFFF_7FFF.
- Signed mul 0xFFFD × 0x0007 → result 0xFFFF_FFEB, done exactly 17 cycles after the start edge. Also: a start pulse at cycle 5 is ignored, and busy stays 1.
- Signed div 0xFFF9 ÷ 0x0002 → result 0xFFFD_FFFF. Signed div 0x8000 ÷ 0xFFFF → err 11, result 0x8000_0000.
- Unsigned div 0x1234 ÷ 0 → err 10, result 0xFFFF_1234, latency 1. Also: op 5'h03 → err 01, result 0.
- Assert reset at cycle 5 of an unsigned mul → all outputs return to 0 and no done pulse occurs. A subsequent back-to-back sequence (a mul immediately followed by an add started in the done cycle) completes correctly.
